// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-unit types: forwarding codes, "operand unused" tag and the scoreboard slot layout.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned T_W    = 2;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_e;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [REG_AW-1:0] dst;
    logic [T_W-1:0]    tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [T_W-1:0]    rs_use;
    logic [T_W-1:0]    rt_use;
  } slot_t;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One scoreboard entry: loads the upstream entry with tnew counted down one stage, or a bubble.
module hazard_slot
  import hazard_scoreboard_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  slot_t din,
  input  logic  bubble,
  output slot_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q      <= din;
      q.tnew <= sat_dec(din.tnew);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall and D/E/M forwarding selects from a 3-slot (E/M/W) write scoreboard.
// Optional HAZARD_STALL_CNT_EN adds a free-running stall-cycle counter output.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [1:0] d_tnew,
  input  logic [4:0] d_dst,
  input  logic       d_regwrite,
  output logic       stall,
  output logic [1:0] d_fwd_rs,
  output logic [1:0] d_fwd_rt,
  output logic [1:0] e_fwd_rs,
  output logic [1:0] e_fwd_rt,
  output logic [1:0] m_fwd_rt
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  slot_t d_entry, e_slot, m_slot, w_slot;

  always_comb begin
    d_entry          = '0;
    d_entry.valid    = d_valid;
    d_entry.regwrite = d_regwrite;
    d_entry.dst      = d_dst;
    d_entry.tnew     = d_tnew;
    d_entry.rs       = d_rs;
    d_entry.rt       = d_rt;
    d_entry.rs_use   = d_rs_tuse;
    d_entry.rt_use   = d_rt_tuse;
  end

  hazard_slot u_slot_e (.clk(clk), .reset(reset), .din(d_entry), .bubble(stall),  .q(e_slot));
  hazard_slot u_slot_m (.clk(clk), .reset(reset), .din(e_slot),  .bubble(1'b0),   .q(m_slot));
  hazard_slot u_slot_w (.clk(clk), .reset(reset), .din(m_slot),  .bubble(1'b0),   .q(w_slot));

  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != '0);
  endfunction

  function automatic logic too_late(input slot_t s, input logic [REG_AW-1:0] r,
                                    input logic [T_W-1:0] tuse);
    return (tuse != TUSE_NONE) && writes(s, r) && (s.tnew > tuse);
  endfunction

  // A younger matching slot decides the source even when its result is not ready yet.
  function automatic fwd_e pick(input slot_t s, input logic [REG_AW-1:0] r,
                                input fwd_e code, input fwd_e older);
    if (writes(s, r)) return (s.tnew == '0) ? code : FWD_RF;
    return older;
  endfunction

  always_comb begin
    stall = d_valid &&
            (too_late(e_slot, d_rs, d_rs_tuse) || too_late(e_slot, d_rt, d_rt_tuse) ||
             too_late(m_slot, d_rs, d_rs_tuse) || too_late(m_slot, d_rt, d_rt_tuse) ||
             too_late(w_slot, d_rs, d_rs_tuse) || too_late(w_slot, d_rt, d_rt_tuse));
    d_fwd_rs = pick(e_slot, d_rs, FWD_E, pick(m_slot, d_rs, FWD_M, pick(w_slot, d_rs, FWD_W, FWD_RF)));
    d_fwd_rt = pick(e_slot, d_rt, FWD_E, pick(m_slot, d_rt, FWD_M, pick(w_slot, d_rt, FWD_W, FWD_RF)));
    e_fwd_rs = pick(m_slot, e_slot.rs, FWD_M, pick(w_slot, e_slot.rs, FWD_W, FWD_RF));
    e_fwd_rt = pick(m_slot, e_slot.rt, FWD_M, pick(w_slot, e_slot.rt, FWD_W, FWD_RF));
    m_fwd_rt = pick(w_slot, m_slot.rt, FWD_W, FWD_RF);
  end

  logic unused_fields;
  assign unused_fields = ^{e_slot.rs_use, e_slot.rt_use, m_slot.rs, m_slot.rs_use, m_slot.rt_use,
                           w_slot.rs, w_slot.rt, w_slot.rs_use, w_slot.rt_use};

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      stall_count <= '0;
    else if (stall) stall_count <= stall_count + 32'd1;
  end
`endif

endmodule
